// File: rtl/stmt_lowerer_scan_pkg.sv
// Shared types for the sequential rule scanner: match modes, FSM states and
// the rule-index width helper.
package stmt_lowerer_scan_pkg;

  localparam int unsigned MODE_W = 2;

  typedef enum logic [MODE_W-1:0] {
    MODE_EXACT    = 2'd0,
    MODE_WILDCARD = 2'd1,
    MODE_RANGE    = 2'd2,
    MODE_TOL      = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_DONE = 2'd2
  } state_e;

  // Index width never drops below one bit, even for a single rule.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/stmt_lowerer_rule_match.sv
// Combinational single-rule evaluator: compares a key against operands A/B
// under one of four match modes.
module stmt_lowerer_rule_match
  import stmt_lowerer_scan_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] key_i,
  input  mode_e            mode_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             match_c_o
);

  localparam int unsigned EXT_W = WIDTH + 1;
  localparam logic [EXT_W-1:0] MAX_EXT = {1'b0, {WIDTH{1'b1}}};

  logic [EXT_W-1:0] a_ext;
  logic [EXT_W-1:0] b_ext;
  logic [EXT_W-1:0] key_ext;
  logic [EXT_W-1:0] sum_ext;
  logic [EXT_W-1:0] lo_ext;
  logic [EXT_W-1:0] hi_ext;

  // Tolerance window bounds, saturated at 0 and at the key's maximum value.
  always_comb begin
    a_ext   = {1'b0, a_i};
    b_ext   = {1'b0, b_i};
    key_ext = {1'b0, key_i};
    sum_ext = a_ext + b_ext;
    lo_ext  = (a_i >= b_i) ? (a_ext - b_ext) : '0;
    hi_ext  = (sum_ext > MAX_EXT) ? MAX_EXT : sum_ext;
  end

  always_comb begin
    match_c_o = 1'b0;
    case (mode_i)
      MODE_EXACT:    match_c_o = (key_i == a_i);
      MODE_WILDCARD: match_c_o = (((key_i ^ a_i) & ~b_i) == '0);
      MODE_RANGE:    match_c_o = (a_i <= b_i) && (key_i >= a_i) && (key_i <= b_i);
      MODE_TOL:      match_c_o = (key_ext >= lo_ext) && (key_ext <= hi_ext);
      default:       match_c_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/stmt_lowerer_rule_scan.sv
// Sequential first-match rule scanner: accepts a key, walks the programmable
// rules one per cycle and reports the first enabled match (or miss/abort).
module stmt_lowerer_rule_scan
  import stmt_lowerer_scan_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned NUM_RULES = 4,
  parameter int unsigned IDX_W     = idx_width(NUM_RULES)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_key,
  input  logic [NUM_RULES-1:0]       rule_en,
  input  logic [NUM_RULES*2-1:0]     rule_mode,
  input  logic [NUM_RULES*WIDTH-1:0] rule_a,
  input  logic [NUM_RULES*WIDTH-1:0] rule_b,
  input  logic                       abort,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       out_hit,
  output logic [IDX_W-1:0]           out_idx,
  output logic                       out_aborted,
  output logic [IDX_W:0]             out_count
);

  localparam int unsigned CNT_W = IDX_W + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_RULES - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] key_q, key_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic             out_hit_q, out_hit_d;
  logic [IDX_W-1:0] out_idx_q, out_idx_d;
  logic             out_aborted_q, out_aborted_d;
  logic [CNT_W-1:0] out_count_q, out_count_d;

  logic             en_arr   [NUM_RULES];
  mode_e            mode_arr [NUM_RULES];
  logic [WIDTH-1:0] a_arr    [NUM_RULES];
  logic [WIDTH-1:0] b_arr    [NUM_RULES];

  logic             sel_en;
  mode_e            sel_mode;
  logic [WIDTH-1:0] sel_a;
  logic [WIDTH-1:0] sel_b;
  logic             sel_match_c;

  // Unpack the flat rule buses so the current rule can be picked by index.
  for (genvar g = 0; g < NUM_RULES; g++) begin : g_unpack
    assign en_arr[g]   = rule_en[g];
    assign mode_arr[g] = mode_e'(rule_mode[2*g +: 2]);
    assign a_arr[g]    = rule_a[WIDTH*g +: WIDTH];
    assign b_arr[g]    = rule_b[WIDTH*g +: WIDTH];
  end

  assign sel_en   = en_arr[idx_q];
  assign sel_mode = mode_arr[idx_q];
  assign sel_a    = a_arr[idx_q];
  assign sel_b    = b_arr[idx_q];

  stmt_lowerer_rule_match #(
    .WIDTH (WIDTH)
  ) u_match (
    .key_i     (key_q),
    .mode_i    (sel_mode),
    .a_i       (sel_a),
    .b_i       (sel_b),
    .match_c_o (sel_match_c)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      key_q         <= '0;
      idx_q         <= '0;
      count_q       <= '0;
      in_ready_q    <= 1'b1;
      out_valid_q   <= 1'b0;
      out_hit_q     <= 1'b0;
      out_idx_q     <= '0;
      out_aborted_q <= 1'b0;
      out_count_q   <= '0;
    end else begin
      state_q       <= state_d;
      key_q         <= key_d;
      idx_q         <= idx_d;
      count_q       <= count_d;
      in_ready_q    <= in_ready_d;
      out_valid_q   <= out_valid_d;
      out_hit_q     <= out_hit_d;
      out_idx_q     <= out_idx_d;
      out_aborted_q <= out_aborted_d;
      out_count_q   <= out_count_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    key_d         = key_q;
    idx_d         = idx_q;
    count_d       = count_q;
    out_hit_d     = out_hit_q;
    out_idx_d     = out_idx_q;
    out_aborted_d = out_aborted_q;
    out_count_d   = out_count_q;

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          key_d   = in_key;
          idx_d   = '0;
          count_d = '0;
          state_d = S_SCAN;
        end
      end
      S_SCAN: begin
        // Abort wins over a match; the rule under evaluation is not counted.
        if (abort) begin
          state_d       = S_DONE;
          out_hit_d     = 1'b0;
          out_idx_d     = '0;
          out_aborted_d = 1'b1;
          out_count_d   = count_q;
        end else begin
          count_d = count_q + CNT_W'(1);
          if (sel_en && sel_match_c) begin
            state_d       = S_DONE;
            out_hit_d     = 1'b1;
            out_idx_d     = idx_q;
            out_aborted_d = 1'b0;
            out_count_d   = count_q + CNT_W'(1);
          end else if (idx_q == LAST_IDX) begin
            state_d       = S_DONE;
            out_hit_d     = 1'b0;
            out_idx_d     = '0;
            out_aborted_d = 1'b0;
            out_count_d   = count_q + CNT_W'(1);
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    in_ready_d  = (state_d == S_IDLE);
    out_valid_d = (state_d == S_DONE);
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign out_hit     = out_hit_q;
  assign out_idx     = out_idx_q;
  assign out_aborted = out_aborted_q;
  assign out_count   = out_count_q;

endmodule

// File: tb/tb_stmt_lowerer_rule_scan.sv
// Directed bench for the rule scanner: 4-rule instance for the main cases
// and a 1-rule instance for the degenerate configuration.
module tb_stmt_lowerer_rule_scan;

  localparam logic [1:0] EX = 2'd0;
  localparam logic [1:0] WC = 2'd1;
  localparam logic [1:0] RG = 2'd2;
  localparam logic [1:0] TL = 2'd3;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_key;
  logic [3:0]  rule_en;
  logic [7:0]  rule_mode;
  logic [31:0] rule_a;
  logic [31:0] rule_b;
  logic        abort;
  logic        out_valid;
  logic        out_ready;
  logic        out_hit;
  logic [1:0]  out_idx;
  logic        out_aborted;
  logic [2:0]  out_count;

  logic        s_in_valid;
  logic        s_in_ready;
  logic [7:0]  s_in_key;
  logic [0:0]  s_rule_en;
  logic [1:0]  s_rule_mode;
  logic [7:0]  s_rule_a;
  logic [7:0]  s_rule_b;
  logic        s_abort;
  logic        s_out_valid;
  logic        s_out_ready;
  logic        s_out_hit;
  logic [0:0]  s_out_idx;
  logic        s_out_aborted;
  logic [1:0]  s_out_count;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  stmt_lowerer_rule_scan #(.WIDTH(8), .NUM_RULES(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_key(in_key),
    .rule_en(rule_en), .rule_mode(rule_mode), .rule_a(rule_a), .rule_b(rule_b),
    .abort(abort), .out_valid(out_valid), .out_ready(out_ready), .out_hit(out_hit),
    .out_idx(out_idx), .out_aborted(out_aborted), .out_count(out_count)
  );

  stmt_lowerer_rule_scan #(.WIDTH(8), .NUM_RULES(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_ready(s_in_ready), .in_key(s_in_key),
    .rule_en(s_rule_en), .rule_mode(s_rule_mode), .rule_a(s_rule_a), .rule_b(s_rule_b),
    .abort(s_abort), .out_valid(s_out_valid), .out_ready(s_out_ready), .out_hit(s_out_hit),
    .out_idx(s_out_idx), .out_aborted(s_out_aborted), .out_count(s_out_count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_rule(input int i, input logic en, input logic [1:0] m,
                          input logic [7:0] a, input logic [7:0] b);
    rule_en[i]          = en;
    rule_mode[2*i +: 2] = m;
    rule_a[8*i +: 8]    = a;
    rule_b[8*i +: 8]    = b;
  endtask

  // Offer a key for one cycle; returns in cycle T+1.
  task automatic send(input string tag, input logic [7:0] k);
    check({tag, "_ready"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_key   = k;
    step();
    in_valid = 1'b0;
  endtask

  // Latency in cycles from the accept cycle T, bounded.
  task automatic wait_valid(output int lat);
    lat = 1;
    while (!out_valid && lat < 20) begin
      step();
      lat++;
    end
  endtask

  task automatic handshake(input string tag);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check({tag, "_valid_drop"}, 32'(out_valid), 32'd0);
    check({tag, "_ready_back"}, 32'(in_ready), 32'd1);
  endtask

  task automatic run(input string tag, input logic [7:0] k, input logic hit,
                     input logic [1:0] idx, input logic [2:0] cnt, input int lat_exp);
    int lat;
    send(tag, k);
    wait_valid(lat);
    check({tag, "_latency"}, 32'(lat), 32'(lat_exp));
    check({tag, "_hit"}, 32'(out_hit), 32'(hit));
    check({tag, "_idx"}, 32'(out_idx), 32'(idx));
    check({tag, "_count"}, 32'(out_count), 32'(cnt));
    check({tag, "_aborted"}, 32'(out_aborted), 32'd0);
    check({tag, "_busy"}, 32'(in_ready), 32'd0);
    handshake(tag);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    rst = 1'b1;
    in_valid = 1'b0; in_key = '0; abort = 1'b0; out_ready = 1'b0;
    rule_en = '0; rule_mode = '0; rule_a = '0; rule_b = '0;
    s_in_valid = 1'b0; s_in_key = '0; s_abort = 1'b0; s_out_ready = 1'b0;
    s_rule_en = 1'b1; s_rule_mode = EX; s_rule_a = 8'h5A; s_rule_b = '0;
    step(); step();
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_hit", 32'(out_hit), 32'd0);
    check("rst_out_idx", 32'(out_idx), 32'd0);
    check("rst_out_aborted", 32'(out_aborted), 32'd0);
    check("rst_out_count", 32'(out_count), 32'd0);
    rst = 1'b0;
    step();

    // All EXACT rules.
    set_rule(0, 1'b1, EX, 8'h10, 8'h00);
    set_rule(1, 1'b1, EX, 8'h20, 8'h00);
    set_rule(2, 1'b1, EX, 8'h30, 8'h00);
    set_rule(3, 1'b1, EX, 8'h40, 8'h00);
    run("exact_30", 8'h30, 1'b1, 2'd2, 3'd3, 4);

    // Wildcard and range rules.
    set_rule(0, 1'b1, WC, 8'h40, 8'h0F);
    set_rule(1, 1'b1, RG, 8'h10, 8'h1F);
    set_rule(2, 1'b1, RG, 8'h20, 8'h10);
    set_rule(3, 1'b1, EX, 8'h77, 8'h00);
    run("wild_4c", 8'h4C, 1'b1, 2'd0, 3'd1, 2);
    run("range_15", 8'h15, 1'b1, 2'd1, 3'd2, 3);
    rule_en = 4'b1101;
    run("rev_range_18", 8'h18, 1'b0, 2'd0, 3'd4, 5);

    // Saturating tolerance windows.
    set_rule(0, 1'b1, TL, 8'h02, 8'h05);
    set_rule(1, 1'b1, TL, 8'hFE, 8'h05);
    set_rule(2, 1'b1, EX, 8'h33, 8'h00);
    set_rule(3, 1'b1, EX, 8'h33, 8'h00);
    run("tol_lo_00", 8'h00, 1'b1, 2'd0, 3'd1, 2);
    run("tol_hi_ff", 8'hFF, 1'b1, 2'd1, 3'd2, 3);
    run("tol_miss_f8", 8'hF8, 1'b0, 2'd0, 3'd4, 5);

    // Disabled matching rule is skipped.
    set_rule(0, 1'b1, EX, 8'h01, 8'h00);
    set_rule(1, 1'b1, EX, 8'h02, 8'h00);
    set_rule(2, 1'b0, EX, 8'h55, 8'h00);
    set_rule(3, 1'b1, EX, 8'h04, 8'h00);
    run("disabled_55", 8'h55, 1'b0, 2'd0, 3'd4, 5);

    // Abort in cycle T+2.
    rule_en = 4'hF;
    send("abort", 8'h99);
    step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("abort_valid", 32'(out_valid), 32'd1);
    check("abort_hit", 32'(out_hit), 32'd0);
    check("abort_aborted", 32'(out_aborted), 32'd1);
    check("abort_idx", 32'(out_idx), 32'd0);
    check("abort_count", 32'(out_count), 32'd1);
    handshake("abort");

    // Reset in cycle T+2 discards the scan.
    send("midrst", 8'h04);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("midrst_ready", 32'(in_ready), 32'd1);
    check("midrst_valid", 32'(out_valid), 32'd0);
    for (int i = 0; i < 6; i++) begin
      step();
      check("midrst_no_valid", 32'(out_valid), 32'd0);
    end

    // Result held while the consumer stalls.
    send("hold", 8'h02);
    wait_valid(lat);
    check("hold_latency", 32'(lat), 32'd3);
    for (int i = 0; i < 5; i++) begin
      check("hold_valid", 32'(out_valid), 32'd1);
      check("hold_hit", 32'(out_hit), 32'd1);
      check("hold_idx", 32'(out_idx), 32'd1);
      check("hold_count", 32'(out_count), 32'd2);
      check("hold_aborted", 32'(out_aborted), 32'd0);
      check("hold_busy", 32'(in_ready), 32'd0);
      step();
    end
    handshake("hold");

    // Single-rule instance.
    check("one_ready", 32'(s_in_ready), 32'd1);
    s_in_valid = 1'b1;
    s_in_key   = 8'h5A;
    step();
    s_in_valid = 1'b0;
    lat = 1;
    while (!s_out_valid && lat < 20) begin
      step();
      lat++;
    end
    check("one_latency", 32'(lat), 32'd2);
    check("one_hit", 32'(s_out_hit), 32'd1);
    check("one_idx", 32'(s_out_idx), 32'd0);
    check("one_count", 32'(s_out_count), 32'd1);
    s_out_ready = 1'b1;
    step();
    s_out_ready = 1'b0;
    check("one_valid_drop", 32'(s_out_valid), 32'd0);
    check("one_ready_back", 32'(s_in_ready), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
